// File: rtl/sram_arbiter_2x1.sv
// Two-requester SRAM-like arbiter onto one shared port. An in-order ID FIFO routes returned data.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed m1 priority.
module sram_arbiter_2x1 #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok
);

    localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [MAX_OUT-1:0] fifo_q;
    logic               push, pop, full, empty, head, grant_id, pick_m1;

    assign full     = (count_q == CNT_W'(MAX_OUT));
    assign empty    = (count_q == '0);
    assign grant_id = (state_q == StG1);
    assign push     = s_req & s_addr_ok;
    // A stray data_ok with nothing outstanding is dropped rather than underflowing.
    assign pop      = s_data_ok & ~empty;
    assign head     = fifo_q[rd_ptr_q];

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= 1'b0;
        end else if (push) begin
            last_grant_q <= grant_id;
        end
    end

    assign pick_m1 = m1_req & (~m0_req | ~last_grant_q);
`else
    assign pick_m1 = m1_req;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!full) begin
                    if (pick_m1) begin
                        state_d = StG1;
                    end else if (m0_req) begin
                        state_d = StG0;
                    end
                end
            end
            // A dropped request without handshake releases the grant with no push.
            StG0:    if (push || !m0_req) state_d = StIdle;
            StG1:    if (push || !m1_req) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_req      = 1'b0;
        s_wr       = 1'b0;
        s_size     = 2'd0;
        s_addr     = 32'd0;
        s_wdata    = 32'd0;
        m0_addr_ok = 1'b0;
        m1_addr_ok = 1'b0;
        unique case (state_q)
            StG0: begin
                s_req      = m0_req;
                s_wr       = m0_wr;
                s_size     = m0_size;
                s_addr     = m0_addr;
                s_wdata    = m0_wdata;
                m0_addr_ok = s_addr_ok & m0_req;
            end
            StG1: begin
                s_req      = m1_req;
                s_wr       = m1_wr;
                s_size     = m1_size;
                s_addr     = m1_addr;
                s_wdata    = m1_wdata;
                m1_addr_ok = s_addr_ok & m1_req;
            end
            default: ;
        endcase
        m0_data_ok = pop & ~head;
        m1_data_ok = pop & head;
        m0_rdata   = (pop & ~head) ? s_rdata : 32'd0;
        m1_rdata   = (pop & head) ? s_rdata : 32'd0;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    // MAX_OUT is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fifo_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= grant_id;
                wr_ptr_q         <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter_2x1.sv
// Directed bench for sram_arbiter_2x1: reset, single read, contention, full FIFO, routing,
// simultaneous push/pop and asynchronous reset.
module tb_sram_arbiter_2x1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size, s_size;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int exp_order [4];
    int n_acc;

    always #5 clk = ~clk;

    sram_arbiter_2x1 #(.MAX_OUT(4), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_addr = 0; m1_wdata = 0;
        s_rdata = 0; s_addr_ok = 0; s_data_ok = 0;

        // Reset state, with a stray data_ok present
        #2; s_data_ok = 1; s_rdata = 32'hDEADBEEF; #1;
        check_eq("rst s_req", 32'(s_req), 0);
        check_eq("rst m0_addr_ok", 32'(m0_addr_ok), 0);
        check_eq("rst m0_data_ok", 32'(m0_data_ok), 0);
        check_eq("rst m1_data_ok", 32'(m1_data_ok), 0);
        check_eq("rst m0_rdata", m0_rdata, 0);
        check_eq("rst count", 32'(dut.count_q), 0);
        s_data_ok = 0; s_rdata = 0;
        #9; resetn = 1'b1;

        // Single read from m0
        tick(); m0_req = 1; m0_addr = 32'hBFC00000; #1;
        check_eq("t1 s_req idle", 32'(s_req), 0);
        tick(); #1;
        check_eq("t1 s_req", 32'(s_req), 1);
        check_eq("t1 s_addr", s_addr, 32'hBFC00000);
        check_eq("t1 addr_ok early", 32'(m0_addr_ok), 0);
        tick(); #1;
        tick(); s_addr_ok = 1; #1;
        check_eq("t1 m0_addr_ok", 32'(m0_addr_ok), 1);
        check_eq("t1 m1_addr_ok", 32'(m1_addr_ok), 0);
        tick(); m0_req = 0; s_addr_ok = 0; #1;
        check_eq("t1 addr_ok once", 32'(m0_addr_ok), 0);
        check_eq("t1 count 1", 32'(dut.count_q), 1);
        tick(); tick(); tick(); s_data_ok = 1; s_rdata = 32'h3C1D0001; #1;
        check_eq("t1 m0_data_ok", 32'(m0_data_ok), 1);
        check_eq("t1 m0_rdata", m0_rdata, 32'h3C1D0001);
        check_eq("t1 m1_data_ok", 32'(m1_data_ok), 0);
        check_eq("t1 m1_rdata", m1_rdata, 0);
        tick(); s_data_ok = 0; s_rdata = 0; #1;
        check_eq("t1 count 0", 32'(dut.count_q), 0);

        // Contention
`ifdef ARB_ROUND_ROBIN_EN
        n_acc = 4; exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
`else
        n_acc = 2; exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif
        tick(); m0_req = 1; m0_addr = 32'h2000; m1_req = 1; m1_addr = 32'h1000; s_addr_ok = 1;
        #1;
        check_eq("t2 s_req idle", 32'(s_req), 0);
        for (int i = 0; i < n_acc; i++) begin
            tick(); #1;
            check_eq("t2 m1_addr_ok", 32'(m1_addr_ok), 32'(exp_order[i]));
            check_eq("t2 m0_addr_ok", 32'(m0_addr_ok), 32'(exp_order[i] == 0));
            check_eq("t2 s_addr", s_addr, (exp_order[i] != 0) ? 32'h1000 : 32'h2000);
            tick();
`ifndef ARB_ROUND_ROBIN_EN
            if (exp_order[i] != 0) m1_req = 0; else m0_req = 0;
`endif
            #1;
            check_eq("t2 bubble", 32'(s_req), 0);
        end
        m0_req = 0; m1_req = 0; s_addr_ok = 0;
        check_eq("t2 count", 32'(dut.count_q), 32'(n_acc));
        for (int i = 0; i < n_acc; i++) begin
            s_data_ok = 1; s_rdata = 32'h100 + 32'(i); #1;
            check_eq("t2 ret m1", 32'(m1_data_ok), 32'(exp_order[i]));
            check_eq("t2 ret m0", 32'(m0_data_ok), 32'(exp_order[i] == 0));
            tick();
        end
        s_data_ok = 0; #1;
        check_eq("t2 count 0", 32'(dut.count_q), 0);

        // Full FIFO blocks new grants
        m1_req = 1; m1_addr = 32'h3000; s_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); tick();
        end
        m1_req = 0; m0_req = 1; #1;
        check_eq("t3 count 4", 32'(dut.count_q), 4);
        check_eq("t3 s_req full", 32'(s_req), 0);
        tick(); #1; check_eq("t3 s_req full 1", 32'(s_req), 0);
        tick(); #1; check_eq("t3 s_req full 2", 32'(s_req), 0);
        s_data_ok = 1; s_rdata = 32'hAAAA0000; #1;
        check_eq("t3 m1_data_ok", 32'(m1_data_ok), 1);
        check_eq("t3 m1_rdata", m1_rdata, 32'hAAAA0000);
        check_eq("t3 m0_data_ok", 32'(m0_data_ok), 0);
        tick(); s_data_ok = 0; #1;
        check_eq("t3 idle after pop", 32'(s_req), 0);
        tick(); #1;
        check_eq("t3 grant m0", 32'(s_req), 1);
        check_eq("t3 m0_addr_ok", 32'(m0_addr_ok), 1);
        tick(); m0_req = 0; s_addr_ok = 0; #1;
        check_eq("t3 refull", 32'(dut.count_q), 4);
        for (int i = 0; i < 4; i++) begin
            s_data_ok = 1; #1;
            check_eq("t3 drain m1", 32'(m1_data_ok), 32'(i < 3));
            check_eq("t3 drain m0", 32'(m0_data_ok), 32'(i == 3));
            tick();
        end
        s_data_ok = 0;

        // Routing: m0 read then m1 write
        s_addr_ok = 1; m0_req = 1; m0_addr = 32'h4000;
        tick(); tick();
        m0_req = 0; m1_req = 1; m1_wr = 1; m1_wdata = 32'hCAFE0001;
        tick(); #1;
        check_eq("t4 s_wr", 32'(s_wr), 1);
        check_eq("t4 s_wdata", s_wdata, 32'hCAFE0001);
        check_eq("t4 m1_addr_ok", 32'(m1_addr_ok), 1);
        tick(); m1_req = 0; m1_wr = 0; s_addr_ok = 0;
        s_data_ok = 1; s_rdata = 32'h11111111; #1;
        check_eq("t4 first m0_data_ok", 32'(m0_data_ok), 1);
        check_eq("t4 first m0_rdata", m0_rdata, 32'h11111111);
        check_eq("t4 first m1_data_ok", 32'(m1_data_ok), 0);
        check_eq("t4 first m1_rdata", m1_rdata, 0);
        tick(); s_rdata = 32'h22222222; #1;
        check_eq("t4 second m1_data_ok", 32'(m1_data_ok), 1);
        check_eq("t4 second m1_rdata", m1_rdata, 32'h22222222);
        check_eq("t4 second m0_data_ok", 32'(m0_data_ok), 0);
        check_eq("t4 second m0_rdata", m0_rdata, 0);
        tick(); s_data_ok = 0; s_rdata = 0;

        // Simultaneous push and pop at count 2
        s_addr_ok = 1; m0_req = 1;
        tick(); tick(); tick(); tick();
        m0_req = 0; m1_req = 1;
        tick(); s_data_ok = 1; s_rdata = 32'h33; #1;
        check_eq("t5 m1_addr_ok", 32'(m1_addr_ok), 1);
        check_eq("t5 pop m0", 32'(m0_data_ok), 1);
        check_eq("t5 count pre", 32'(dut.count_q), 2);
        tick(); m1_req = 0; s_addr_ok = 0; s_data_ok = 0; #1;
        check_eq("t5 count post", 32'(dut.count_q), 2);
        s_data_ok = 1; #1;
        check_eq("t5 head m0", 32'(m0_data_ok), 1);
        tick(); #1;
        check_eq("t5 head m1", 32'(m1_data_ok), 1);
        tick(); s_data_ok = 0; #1;
        check_eq("t5 count 0", 32'(dut.count_q), 0);

        // Asynchronous reset mid-grant with count 3
        m0_req = 1; s_addr_ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); tick();
        end
        s_addr_ok = 0;
        tick(); #1;
        check_eq("t6 s_req", 32'(s_req), 1);
        check_eq("t6 count 3", 32'(dut.count_q), 3);
        s_addr_ok = 1; #1;
        check_eq("t6 addr_ok pre", 32'(m0_addr_ok), 1);
        resetn = 0; #1;
        check_eq("t6 s_req rst", 32'(s_req), 0);
        check_eq("t6 addr_ok rst", 32'(m0_addr_ok), 0);
        check_eq("t6 count rst", 32'(dut.count_q), 0);
        m0_req = 0; s_addr_ok = 0;
        tick(); resetn = 1; s_data_ok = 1; s_rdata = 32'h55555555; #1;
        check_eq("t6 spurious m0", 32'(m0_data_ok), 0);
        check_eq("t6 spurious m1", 32'(m1_data_ok), 0);
        check_eq("t6 spurious rdata", m0_rdata, 0);
        tick(); s_data_ok = 0; #1;
        check_eq("t6 count end", 32'(dut.count_q), 0);
        check_eq("t6 s_req end", 32'(s_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
